// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line buffer: default geometry, fill-state encoding
// and a constant-safe clog2 for counter sizing.
package sobel_pkg;

  localparam int PIX_W        = 8;
  localparam int DEF_LINE_LEN = 16;
  localparam int DEF_NUM_TAPS = 3;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } fillState_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sobel_line_buffer_if.sv
// Pixel-in / taps-out bundle of the Sobel line buffer.
// The master drives pixels and clear; the slave (the buffer) returns taps and status.
interface sobel_line_buffer_if
  import sobel_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int NUM_TAPS = DEF_NUM_TAPS
);

  logic                       Clear;
  logic                       Enable;
  logic [DATA_W-1:0]          DataIn;
  logic [NUM_TAPS*DATA_W-1:0] Taps;
  logic                       TapValid;
  logic                       Full;

  modport master (
    output Clear, Enable, DataIn,
    input  Taps, TapValid, Full
  );

  modport slave (
    input  Clear, Enable, DataIn,
    output Taps, TapValid, Full
  );

endinterface

// File: rtl/sobel_line_buffer_line_delay_seg.sv
// One image line of delay: LINE_LEN enable-gated cells with synchronous clear.
// dOut is the last cell, so chaining segments yields taps one line apart.
module line_delay_seg
  import sobel_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int LINE_LEN = DEF_LINE_LEN
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Clear,
  input  logic              Enable,
  input  logic [DATA_W-1:0] dIn,
  output logic [DATA_W-1:0] dOut
);

  logic [DATA_W-1:0] cells [LINE_LEN];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < LINE_LEN; i++) cells[i] <= '0;
    end else if (Clear) begin
      for (int i = 0; i < LINE_LEN; i++) cells[i] <= '0;
    end else if (Enable) begin
      cells[0] <= dIn;
      for (int i = 1; i < LINE_LEN; i++) cells[i] <= cells[i-1];
    end
  end

  assign dOut = cells[LINE_LEN-1];

endmodule

// File: rtl/sobel_line_buffer.sv
// Multi-row pixel delay line feeding the Sobel 3x3 window, with fill tracking
// so the window logic knows when every tap holds real image data.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int NUM_TAPS = DEF_NUM_TAPS
) (
  input  logic                CLK,
  input  logic                RST_n,
  sobel_line_buffer_if.slave  lineBus
);

  localparam int N     = (NUM_TAPS - 1) * LINE_LEN + 1;
  localparam int CNT_W = clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  fillState_e                 state, stateNext;
  logic [CNT_W-1:0]           fillCnt, fillNext;
  logic                       full, tapValid, tapValidNext;
  logic                       accept;
  logic [DATA_W-1:0]          cell0;
  logic [DATA_W-1:0]          tapW [NUM_TAPS];
  logic [NUM_TAPS*DATA_W-1:0] tapsFlat;

  assign accept = lineBus.Enable & ~lineBus.Clear;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)             cell0 <= '0;
    else if (lineBus.Clear) cell0 <= '0;
    else if (accept)        cell0 <= lineBus.DataIn;
  end

  assign tapW[0] = cell0;

  // Each segment adds one line of delay, so tap k sits at cell k*LINE_LEN.
  for (genvar k = 1; k < NUM_TAPS; k++) begin : gSeg
    line_delay_seg #(
      .DATA_W   (DATA_W),
      .LINE_LEN (LINE_LEN)
    ) uSeg (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .Clear  (lineBus.Clear),
      .Enable (lineBus.Enable),
      .dIn    (tapW[k-1]),
      .dOut   (tapW[k])
    );
  end

  always_comb begin
    tapsFlat = '0;
    for (int k = 0; k < NUM_TAPS; k++) tapsFlat[k*DATA_W +: DATA_W] = tapW[k];
  end

  always_comb begin
    stateNext    = state;
    fillNext     = fillCnt;
    tapValidNext = 1'b0;
    if (lineBus.Clear) begin
      stateNext = FILL;
      fillNext  = '0;
    end else if (accept) begin
      tapValidNext = (fillCnt == CNT_LAST) || (state == STREAM);
      if (state == FILL) begin
        fillNext = fillCnt + 1'b1;
        if (fillCnt == CNT_LAST) stateNext = STREAM;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= FILL;
      fillCnt  <= '0;
      full     <= 1'b0;
      tapValid <= 1'b0;
    end else begin
      state    <= stateNext;
      fillCnt  <= fillNext;
      full     <= (fillNext == CNT_FULL);
      tapValid <= tapValidNext;
    end
  end

  assign lineBus.Taps     = tapsFlat;
  assign lineBus.TapValid = tapValid;
  assign lineBus.Full     = full;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer: default geometry plus a 10-bit / 4-wide / 5-tap instance.
module tb_sobel_line_buffer;

  localparam int N1 = 33;

  logic CLK;
  logic RST_n;
  int   nChecks = 0;
  int   nErrors = 0;

  sobel_line_buffer_if #(.DATA_W(8),  .NUM_TAPS(3)) lb1 ();
  sobel_line_buffer_if #(.DATA_W(10), .NUM_TAPS(5)) lb2 ();

  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(16), .NUM_TAPS(3)) uDut1 (
    .CLK(CLK), .RST_n(RST_n), .lineBus(lb1.slave));

  sobel_line_buffer #(.DATA_W(10), .LINE_LEN(4), .NUM_TAPS(5)) uDut2 (
    .CLK(CLK), .RST_n(RST_n), .lineBus(lb2.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference chain for the default instance.
  logic [7:0]  mc [N1];
  int          mFill;
  bit          mStream;
  logic [23:0] expQ [$];
  logic [7:0]  pix;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N1; i++) mc[i] = '0;
    mFill   = 0;
    mStream = 0;
    expQ.delete();
  endtask

  function automatic logic [23:0] modelTaps();
    return {mc[32], mc[16], mc[0]};
  endfunction

  task automatic cyc1(input bit clr, input bit en, input logic [7:0] din);
    bit expValid;
    lb1.Clear  = clr;
    lb1.Enable = en;
    lb1.DataIn = din;
    @(posedge CLK);
    expValid = 0;
    if (clr) begin
      for (int i = 0; i < N1; i++) mc[i] = '0;
      mFill   = 0;
      mStream = 0;
    end else if (en) begin
      expValid = (mFill == N1 - 1) || mStream;
      for (int i = N1 - 1; i > 0; i--) mc[i] = mc[i-1];
      mc[0] = din;
      if (mFill < N1) mFill++;
      mStream = (mFill == N1);
      if (expValid) expQ.push_back(modelTaps());
    end
    #1;
    chk("tapValid", 64'(lb1.TapValid), 64'(expValid));
    chk("full", 64'(lb1.Full), 64'(mFill == N1));
    chk("taps", 64'(lb1.Taps), 64'(modelTaps()));
    if (lb1.TapValid) begin
      if (expQ.size() == 0) chk("sbPop", 64'(expQ.size()), 64'd1);
      else chk("sbTaps", 64'(lb1.Taps), 64'(expQ.pop_front()));
    end
  endtask

  task automatic resetPulse(input bit randEn);
    @(posedge CLK);
    #3;
    RST_n = 1'b0;
    modelReset();
    #1;
    chk("rstTaps", 64'(lb1.Taps), 64'd0);
    chk("rstValid", 64'(lb1.TapValid), 64'd0);
    chk("rstFull", 64'(lb1.Full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      lb1.Enable = randEn ? 1'($urandom_range(0, 1)) : 1'b0;
      lb1.DataIn = 8'($urandom);
      @(posedge CLK);
      #1;
      chk("rstHoldTaps", 64'(lb1.Taps), 64'd0);
      chk("rstHoldValid", 64'(lb1.TapValid), 64'd0);
      chk("rstHoldFull", 64'(lb1.Full), 64'd0);
    end
    lb1.Enable = 1'b0;
    #2;
    RST_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  d;
    logic [49:0] e2;
    RST_n      = 1'b1;
    lb1.Clear  = 1'b0;
    lb1.Enable = 1'b0;
    lb1.DataIn = '0;
    lb2.Clear  = 1'b0;
    lb2.Enable = 1'b0;
    lb2.DataIn = '0;
    modelReset();
    #2;
    resetPulse(1'b1);

    // Fill with a ramp: first valid taps only after the 33rd accept.
    for (int i = 0; i < N1; i++) cyc1(1'b0, 1'b1, 8'(i));
    chk("fillValid", 64'(lb1.TapValid), 64'd1);
    chk("fillTaps", 64'(lb1.Taps), 64'h00_10_20);
    chk("fillFull", 64'(lb1.Full), 64'd1);
    pix = 8'd33;

    // Streaming with Enable gaps: alignment is counted in accepts.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        cyc1(1'b0, 1'b1, pix);
        pix++;
      end else begin
        cyc1(1'b0, 1'b0, 8'hFF);
      end
      d = lb1.Taps[7:0] - lb1.Taps[15:8];
      chk("gapDiff01", 64'(d), 64'd16);
      d = lb1.Taps[15:8] - lb1.Taps[23:16];
      chk("gapDiff12", 64'(d), 64'd16);
    end

    // Clear wins over Enable.
    cyc1(1'b1, 1'b1, 8'hAA);
    chk("clrTaps", 64'(lb1.Taps), 64'd0);
    chk("clrFull", 64'(lb1.Full), 64'd0);
    chk("clrValid", 64'(lb1.TapValid), 64'd0);
    for (int i = 0; i < N1; i++) begin
      cyc1(1'b0, 1'b1, pix);
      pix++;
    end
    chk("refillValid", 64'(lb1.TapValid), 64'd1);
    cyc1(1'b0, 1'b0, 8'h00);

    // Reset mid-fill: refill needs a fresh 33 accepts.
    cyc1(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) cyc1(1'b0, 1'b1, 8'(100 + i));
    resetPulse(1'b0);
    for (int i = 0; i < N1; i++) cyc1(1'b0, 1'b1, 8'(200 + i));
    chk("postRstValid", 64'(lb1.TapValid), 64'd1);
    chk("postRstTaps", 64'(lb1.Taps), 64'(modelTaps()));
    cyc1(1'b0, 1'b0, 8'h00);
    chk("sbDrain", 64'(expQ.size()), 64'd0);

    // Second geometry: N = 17.
    for (int i = 1; i <= 17; i++) begin
      lb2.Enable = 1'b1;
      lb2.DataIn = 10'(i);
      @(posedge CLK);
      #1;
      chk("p2Valid", 64'(lb2.TapValid), 64'(i == 17));
      chk("p2Full", 64'(lb2.Full), 64'(i == 17));
    end
    lb2.Enable = 1'b0;
    for (int k = 0; k < 5; k++) e2[k*10 +: 10] = 10'(17 - 4 * k);
    chk("p2Taps", 64'(lb2.Taps), 64'(e2));
    @(posedge CLK);
    #1;
    chk("p2Idle", 64'(lb2.TapValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
- Parametrised multi-row pixel delay line for the Sobel datapath; successor to the fixed 8/16-cell enable-gated FIFO chain.
- Accepts one pixel per enabled cycle and exposes NUM_TAPS vertically aligned taps, each spaced LINE_LEN accepted pixels apart.
- Adds a fill tracker, a tap-valid strobe and a synchronous clear, so the downstream 3x3 window logic knows when the taps hold real image data.

Parameters:
- DATA_W, 8, pixel width in bits.
- LINE_LEN, 16, image line length in pixels; spacing between adjacent taps; must be >= 2.
- NUM_TAPS, 3, number of row taps exposed; must be >= 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Clear  input  1  synchronous clear of cells and fill state; takes priority over Enable.
- Enable  input  1  pixel-accept strobe; DataIn is captured when high.
- DataIn  input  DATA_W  incoming pixel.
- Taps  output  NUM_TAPS*DATA_W  Taps[k*DATA_W +: DATA_W] = tap k; tap 0 is the newest pixel.
- TapValid  output  1  one-cycle strobe: taps were updated by the previous accept and all taps hold real data.
- Full  output  1  level: the chain has been completely filled since the last reset/Clear.

Behaviour:
- Chain length N = (NUM_TAPS-1)*LINE_LEN + 1 cells, cell[0..N-1].
- On an accept (Enable=1, Clear=0): cell[0] <= DataIn and cell[i] <= cell[i-1] for i = 1..N-1, all in the same edge. With Enable=0, every cell holds.
- Tap k = cell[k*LINE_LEN]. Taps are direct register outputs, so latency is 1 cycle from DataIn to tap 0.
- Fill counter FillCnt counts 0..N and saturates at N; it is internal, width clog2(N+1).
- Full = (FillCnt == N), registered.
- State machine:
  - FILL (reset state): on an accept, FillCnt increments; when the accept makes FillCnt = N, go to STREAM.
  - STREAM: FillCnt is held at N.
  - Any state: Clear -> FILL.
- TapValid <= accept AND (FillCnt == N-1 OR state == STREAM). It is high in the cycle the taps show the new data, and only on accepts.
- Clear=1 at an edge: all cells, FillCnt, Full and TapValid go to 0 and the state goes to FILL. Enable is ignored in that cycle.
- RST_n low, asynchronously: all cells = 0, FillCnt = 0, state = FILL, Taps = 0, TapValid = 0, Full = 0. This applies mid-stream too; there is no partial retention. Reset deassertion is synchronised externally.
- Gaps in Enable (back-pressure or blanking) never corrupt alignment, because the taps are counted in accepts, not cycles.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W = 8 and default LINE_LEN/NUM_TAPS constants.
  - Fill-state encoding: FILL = 1'b0, STREAM = 1'b1.
  - A clog2 function.
- One sub-module, line_delay_seg: a LINE_LEN-cell enable-gated shift segment with clear and async reset. It is instantiated NUM_TAPS-1 times after cell[0] via a generate loop.
- The fill FSM and counter stay in the top level.

Test Plan:
- Reset/idle: assert RST_n=0 mid-cycle with random Enable -> Taps=0, TapValid=0, Full=0 immediately and held until release.
- Fill: defaults, one accept per cycle, DataIn = 0,1,2,... -> TapValid first high the cycle after accepting value 32. At that point Taps = {0,16,32} (tap2,tap1,tap0) and Full=1. TapValid is 0 on all earlier accepts.
- Streaming with gaps: after fill, alternate Enable 1/0 -> TapValid high only after accepts; taps always satisfy tap0 - tap1 = 16 and tap1 - tap2 = 16.
- Clear priority: Clear=1 and Enable=1 with DataIn=0xAA in STREAM -> next cycle all Taps=0, Full=0, TapValid=0. Refill needs 33 accepts again.
- Reset mid-fill: after 20 accepts pulse RST_n low -> state FILL. The first TapValid requires 33 fresh accepts.
- Parameter sweep: DATA_W=10, LINE_LEN=4, NUM_TAPS=5 -> N=17. Feed 1..17 -> Taps = {1,5,9,13,17} and TapValid high after the 17th accept.
